// File: rtl/im_loader.sv
// im_loader: boot-time instruction memory writer.
// Zero-fills the whole instruction store, then assembles a big-endian byte
// stream into 32-bit words and writes them from BASE_ADDR upward while the
// CPU is held in stall.
// Optional build macro: IM_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte that is verified after the last word is written.
module im_loader #(
   parameter int unsigned DEPTH     = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h00003000,
   parameter int unsigned AW        = 11
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [AW-1:0] word_count,
   input  logic          byte_valid,
   input  logic [7:0]    byte_data,
   output logic          byte_ready,
   output logic          im_we,
   output logic [31:0]   im_addr,
   output logic [31:0]   im_wdata,
   output logic          cpu_hold,
   output logic          done,
   output logic          err
);

   localparam int unsigned   IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
   localparam logic [AW-1:0] DEPTH_W  = AW'(DEPTH);

`ifdef IM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, CLEAR, RECV, WRITE, CHK, DONE} state_t;
   localparam state_t TAIL = CHK;
`else
   typedef enum logic [2:0] {IDLE, CLEAR, RECV, WRITE, DONE} state_t;
   localparam state_t TAIL = DONE;
`endif

   state_t          state, state_nx;
   logic [IW-1:0]   clr_idx;
   logic [AW-1:0]   wr_cnt;
   logic [AW-1:0]   wr_nx;
   logic [AW-1:0]   count_q;
   logic [1:0]      byte_cnt;
   logic [31:0]     word;
   logic            oversize;
   logic            take;
`ifdef IM_LOADER_CHECKSUM_EN
   logic [7:0]      csum;
   logic            chk_bad;
`endif

   function automatic logic [31:0] addr_of(input logic [IW-1:0] idx);
      return BASE_ADDR + (32'(idx) << 2);
   endfunction

   assign oversize = (word_count > DEPTH_W);
   assign wr_nx    = wr_cnt + AW'(1);
   assign take     = byte_valid && byte_ready;
   assign done     = (state == DONE);

`ifdef IM_LOADER_CHECKSUM_EN
   // A failed checksum leaves the CPU stalled even though the load is done.
   assign cpu_hold = !((state == DONE) && !chk_bad);
`else
   assign cpu_hold = (state != DONE);
`endif

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state decode and memory/handshake outputs.
   always_comb begin
      state_nx   = state;
      byte_ready = 1'b0;
      im_we      = 1'b0;
      im_addr    = BASE_ADDR;
      im_wdata   = '0;
      case (state)
         IDLE, DONE: begin
            if (start && !oversize) begin
               state_nx = CLEAR;
            end
         end
         CLEAR: begin
            im_we   = 1'b1;
            im_addr = addr_of(clr_idx);
            if (clr_idx == LAST_IDX) begin
               state_nx = (count_q != '0) ? RECV : TAIL;
            end
         end
         RECV: begin
            byte_ready = 1'b1;
            if (byte_valid && (byte_cnt == 2'd3)) begin
               state_nx = WRITE;
            end
         end
         WRITE: begin
            im_we    = 1'b1;
            im_wdata = word;
            im_addr  = addr_of(wr_cnt[IW-1:0]);
            state_nx = (wr_nx == count_q) ? TAIL : RECV;
         end
`ifdef IM_LOADER_CHECKSUM_EN
         CHK: begin
            byte_ready = 1'b1;
            if (byte_valid) begin
               state_nx = DONE;
            end
         end
`endif
         default: state_nx = IDLE;
      endcase
   end

   // Counters, word assembly and error flag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         clr_idx  <= '0;
         wr_cnt   <= '0;
         count_q  <= '0;
         byte_cnt <= '0;
         word     <= '0;
         err      <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
         csum     <= '0;
         chk_bad  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  if (oversize) begin
                     err <= 1'b1;
                  end else begin
                     err      <= 1'b0;
                     count_q  <= word_count;
                     clr_idx  <= '0;
                     wr_cnt   <= '0;
                     byte_cnt <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
                     csum     <= '0;
                     chk_bad  <= 1'b0;
`endif
                  end
               end
            end
            CLEAR: begin
               clr_idx <= (clr_idx == LAST_IDX) ? '0 : clr_idx + IW'(1);
            end
            RECV: begin
               // The 2-bit byte counter wraps to 0 after the 4th byte, so it
               // is already cleared for the next word when WRITE returns here.
               if (take) begin
                  word     <= {word[23:0], byte_data};
                  byte_cnt <= byte_cnt + 2'd1;
`ifdef IM_LOADER_CHECKSUM_EN
                  csum     <= csum ^ byte_data;
`endif
               end
            end
            WRITE: begin
               wr_cnt <= wr_nx;
            end
`ifdef IM_LOADER_CHECKSUM_EN
            CHK: begin
               if (take && (byte_data != csum)) begin
                  err     <= 1'b1;
                  chk_bad <= 1'b1;
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_im_loader.sv
// Directed self-checking bench for im_loader.
module tb_im_loader;

   localparam int unsigned DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h00003000;
   localparam int unsigned AW    = 11;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] word_count = '0;
   logic          byte_valid = 1'b0;
   logic [7:0]    byte_data = '0;
   logic          byte_ready, im_we, cpu_hold, done, err;
   logic [31:0]   im_addr, im_wdata;

   im_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .AW(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .word_count(word_count),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
      .cpu_hold(cpu_hold), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   always @(posedge clk) cyc++;

   // Write / handshake log, sampled on the falling edge.
   logic [31:0] wa[$];
   logic [31:0] wd[$];
   int          wc[$];
   int          hs[$];
   int          rdy_cnt = 0;
   int          overlap = 0;
   int          done_cyc = -1;
   logic        done_q = 1'b0;

   always @(negedge clk) begin
      if (im_we) begin
         wa.push_back(im_addr);
         wd.push_back(im_wdata);
         wc.push_back(cyc);
      end
      if (byte_valid && byte_ready) hs.push_back(cyc);
      if (byte_ready) rdy_cnt++;
      if (im_we && byte_ready) overlap++;
      if (done && !done_q && done_cyc < 0) done_cyc = cyc;
      done_q = done;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      wa.delete(); wd.delete(); wc.delete(); hs.delete();
      rdy_cnt = 0; overlap = 0; done_cyc = -1;
   endtask

   task automatic start_load(input int cnt);
      @(negedge clk);
      word_count = AW'(cnt);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      repeat (gap) @(negedge clk);
      byte_data = b;
      byte_valid = 1'b1;
      t = 0;
      while (!byte_ready && t < 4000) begin
         @(negedge clk);
         t++;
      end
      check("byte_wait", t < 4000, 1);
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic load(input logic [7:0] img[$], input int gap);
      logic [7:0] x;
      x = 8'h00;
      foreach (img[i]) begin
         send_byte(img[i], gap);
         x = x ^ img[i];
      end
`ifdef IM_LOADER_CHECKSUM_EN
      send_byte(x, gap);
`endif
   endtask

   task automatic wait_done(input int budget);
      int t;
      t = 0;
      while (!done && t < budget) begin
         @(negedge clk);
         t++;
      end
      check("done_wait", t < budget, 1);
      @(negedge clk);
   endtask

   task automatic check_clear(input string tag);
      int bad;
      bad = 0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (i >= wa.size()) bad++;
         else if (wa[i] !== BASE + 32'(4 * i) || wd[i] !== 32'h0) bad++;
      end
      check(tag, bad, 0);
   endtask

   task automatic check_reset_vals(input string pfx);
      check({pfx, "_ready"}, byte_ready, 0);
      check({pfx, "_we"}, im_we, 0);
      check({pfx, "_addr"}, im_addr, BASE);
      check({pfx, "_wdata"}, im_wdata, 0);
      check({pfx, "_hold"}, cpu_hold, 1);
      check({pfx, "_done"}, done, 0);
      check({pfx, "_err"}, err, 0);
   endtask

   logic [7:0] img1[$] = '{8'h24, 8'h01, 8'h00, 8'h05, 8'h34, 8'h02, 8'h00, 8'h07};
   logic [7:0] img2[$] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

   initial begin
      // Reset held for two cycles.
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_vals("rst");
      reset = 1'b1;

      // Normal two-word load.
      clear_log();
      start_load(2);
      check("norm_hold_busy", cpu_hold, 1);
      load(img1, 0);
      wait_done(3000);
      check("norm_nwr", wa.size(), DEPTH + 2);
      check_clear("norm_clear");
      check("norm_a0", wa[DEPTH], 32'h00003000);
      check("norm_d0", wd[DEPTH], 32'h24010005);
      check("norm_a1", wa[DEPTH+1], 32'h00003004);
      check("norm_d1", wd[DEPTH+1], 32'h34020007);
      check("norm_lat", wc[DEPTH] - hs[3], 1);
`ifndef IM_LOADER_CHECKSUM_EN
      check("norm_done_lat", done_cyc - wc[DEPTH+1], 1);
`endif
      check("norm_done", done, 1);
      check("norm_hold", cpu_hold, 0);
      check("norm_err", err, 0);

      // Empty image, re-armed from DONE.
      clear_log();
      start_load(0);
      check("empty_hold", cpu_hold, 1);
`ifdef IM_LOADER_CHECKSUM_EN
      send_byte(8'h00, 0);
`endif
      wait_done(3000);
      check("empty_nwr", wa.size(), DEPTH);
      check_clear("empty_clear");
`ifndef IM_LOADER_CHECKSUM_EN
      check("empty_rdy", rdy_cnt, 0);
      check("empty_done_lat", done_cyc - wc[DEPTH-1], 1);
`endif
      check("empty_hold_done", cpu_hold, 0);

      // Oversize request is rejected from IDLE.
      @(negedge clk); reset = 1'b0;
      @(negedge clk); reset = 1'b1;
      clear_log();
      start_load(DEPTH + 1);
      repeat (5) @(negedge clk);
      check("ovr_err", err, 1);
      check("ovr_nwr", wa.size(), 0);
      check("ovr_hold", cpu_hold, 1);
      check("ovr_done", done, 0);
      check("ovr_ready", byte_ready, 0);

      // Same image with gaps between bytes.
      clear_log();
      start_load(2);
      load(img1, 2);
      wait_done(3000);
      check("bp_nwr", wa.size(), DEPTH + 2);
      check("bp_d0", wd[DEPTH], 32'h24010005);
      check("bp_d1", wd[DEPTH+1], 32'h34020007);
      check("bp_a1", wa[DEPTH+1], 32'h00003004);
      check("bp_overlap", overlap, 0);
`ifdef IM_LOADER_CHECKSUM_EN
      check("bp_nhs", hs.size(), 9);
`else
      check("bp_nhs", hs.size(), 8);
`endif
      check("bp_err", err, 0);

      // Reset after two bytes of word 0, then a fresh one-word load.
      clear_log();
      start_load(2);
      send_byte(8'h24, 0);
      send_byte(8'h01, 0);
      reset = 1'b0;
      @(negedge clk);
      check_reset_vals("mid");
      reset = 1'b1;
      clear_log();
      start_load(1);
      load(img2, 0);
      wait_done(3000);
      check("mid_nwr", wa.size(), DEPTH + 1);
      check("mid_a0", wa[DEPTH], 32'h00003000);
      check("mid_d0", wd[DEPTH], 32'hDEADBEEF);

`ifdef IM_LOADER_CHECKSUM_EN
      // Wrong trailing checksum: XOR of img1 is 8'h11.
      clear_log();
      start_load(2);
      foreach (img1[i]) send_byte(img1[i], 0);
      send_byte(8'h15, 0);
      wait_done(3000);
      check("chk_err", err, 1);
      check("chk_done", done, 1);
      check("chk_hold", cpu_hold, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
